// File: rtl/tod_slot_timer_pkg.sv
// Shared definitions for the time-of-day / slot timer.
// Holds the default widths and the default slot end, the {h,l} tod struct at
// the default widths, and the phase-adjust action encoding that the adjust
// unit hands to the counter.
package tod_pkg;

  localparam int unsigned TOD_FINE_W          = 11;
  localparam int unsigned TOD_COARSE_W        = 21;
  localparam int unsigned TOD_FINE_MOD        = 800;   // 800 x 10 ns = 8 us
  localparam int unsigned TOD_SLOT_H_DEF      = 976;
  localparam int unsigned TOD_SLOT_L_DEF      = 449;   // 976*800+449+1 = 781250 clk
  localparam int unsigned TOD_SLOT_W          = 8;
  localparam int unsigned TOD_SLOTS_PER_FRAME = 128;
  localparam int unsigned TOD_ADJ_W           = 8;

  typedef struct packed {
    logic [TOD_COARSE_W-1:0] h;
    logic [TOD_FINE_W-1:0]   l;
  } tod_t;

  // What the counter does on the next fine wrap.
  typedef enum logic [1:0] {
    ADJ_NONE = 2'd0,  // plain wrap to 0
    ADJ_SKIP = 2'd1,  // wrap to 1, dropping one tick
    ADJ_HOLD = 2'd2   // stay on the last fine tick one extra clk
  } adj_act_e;

endpackage

// File: rtl/tod_slot_timer_if.sv
// Bus bundle for tod_slot_timer.
//   master : load/reload/period/adjust controls out, time and strobes in
//   slave  : the timer side
// Signals:
//   rtt_reload_en, reload_tod_h/l : precise RTT load of tod
//   load_en, load_data            : coarse load of tod, load_data = {tod_h, tod_l}
//   per_load_en, per_h/l          : new slot end (inclusive last tick) into shadow
//   adj_req, adj_val              : queue a signed phase adjust in ticks
//   tod_h/l, tod_flag             : time within slot, first-fine-period flag
//   slot_pulse, frame_pulse       : boundary strobes
//   slot_num                      : slot index in frame
//   adj_busy, adj_err             : adjust pending / saturated strobe
interface tod_slot_timer_if
  import tod_pkg::*;
#(
  parameter int unsigned FINE_W   = TOD_FINE_W,
  parameter int unsigned COARSE_W = TOD_COARSE_W,
  parameter int unsigned SLOT_W   = TOD_SLOT_W,
  parameter int unsigned ADJ_W    = TOD_ADJ_W
);

  logic                       rtt_reload_en;
  logic [COARSE_W-1:0]        reload_tod_h;
  logic [FINE_W-1:0]          reload_tod_l;
  logic                       load_en;
  logic [COARSE_W+FINE_W-1:0] load_data;
  logic                       per_load_en;
  logic [COARSE_W-1:0]        per_h;
  logic [FINE_W-1:0]          per_l;
  logic                       adj_req;
  logic signed [ADJ_W-1:0]    adj_val;

  logic [COARSE_W-1:0]        tod_h;
  logic [FINE_W-1:0]          tod_l;
  logic                       tod_flag;
  logic                       slot_pulse;
  logic                       frame_pulse;
  logic [SLOT_W-1:0]          slot_num;
  logic                       adj_busy;
  logic                       adj_err;

  modport master (
    output rtt_reload_en, reload_tod_h, reload_tod_l,
    output load_en, load_data,
    output per_load_en, per_h, per_l,
    output adj_req, adj_val,
    input  tod_h, tod_l, tod_flag, slot_pulse, frame_pulse, slot_num,
    input  adj_busy, adj_err
  );

  modport slave (
    input  rtt_reload_en, reload_tod_h, reload_tod_l,
    input  load_en, load_data,
    input  per_load_en, per_h, per_l,
    input  adj_req, adj_val,
    output tod_h, tod_l, tod_flag, slot_pulse, frame_pulse, slot_num,
    output adj_busy, adj_err
  );

endinterface

// File: rtl/tod_slot_timer_phase_adj.sv
// tod_phase_adj: pending phase-adjust accumulator for the slot timer.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : tod load this cycle; drops pending and stretch
//   wrap      : counter is taking a fine wrap this cycle (consumes act)
//   adj_req   : add adj_val to pending, saturating at +/-(2^(ADJ_W-1)-1)
//   adj_val   : signed ticks, >0 advance, <0 retard
//   act       : action for a fine wrap happening this cycle
//   busy      : pending != 0
//   err       : 1-clk strobe after an adj_req that saturated
module tod_phase_adj
  import tod_pkg::*;
#(
  parameter int unsigned ADJ_W = TOD_ADJ_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wrap,
  input  logic                    adj_req,
  input  logic signed [ADJ_W-1:0] adj_val,
  output adj_act_e                act,
  output logic                    busy,
  output logic                    err
);

  localparam logic signed [ADJ_W:0] SAT_MAX = {2'b00, {(ADJ_W-1){1'b1}}};
  localparam logic signed [ADJ_W:0] SAT_MIN = {2'b11, {(ADJ_W-2){1'b0}}, 1'b1};
  localparam logic signed [ADJ_W:0] ONE     = {{ADJ_W{1'b0}}, 1'b1};

  logic signed [ADJ_W-1:0] pending;
  logic                    stretch;

  logic signed [ADJ_W:0] base;
  logic signed [ADJ_W:0] req_ext;
  logic signed [ADJ_W:0] sum;
  logic signed [ADJ_W:0] sat_val;
  logic                  sat;

  // The cycle after a hold is the stretched wrap itself: it wraps plainly,
  // so no new action is offered while stretch is set.
  always_comb begin
    act = ADJ_NONE;
    if (!stretch && pending != '0) begin
      act = pending[ADJ_W-1] ? ADJ_HOLD : ADJ_SKIP;
    end
  end

  // Applying a step moves pending toward zero, so base stays in range and
  // only the adj_req addition can saturate; both net out in one cycle.
  always_comb begin
    base = {pending[ADJ_W-1], pending};
    if (wrap && act == ADJ_SKIP) begin
      base = base - ONE;
    end else if (wrap && act == ADJ_HOLD) begin
      base = base + ONE;
    end
    req_ext = '0;
    if (adj_req) begin
      req_ext = {adj_val[ADJ_W-1], adj_val};
    end
    sum     = base + req_ext;
    sat     = 1'b0;
    sat_val = sum;
    if (sum > SAT_MAX) begin
      sat_val = SAT_MAX;
      sat     = 1'b1;
    end else if (sum < SAT_MIN) begin
      sat_val = SAT_MIN;
      sat     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      stretch <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      pending <= '0;
      stretch <= 1'b0;
      err     <= 1'b0;
    end else begin
      pending <= sat_val[ADJ_W-1:0];
      err     <= adj_req && sat;
      if (wrap) begin
        stretch <= (act == ADJ_HOLD);
      end
    end
  end

  assign busy = (pending != '0);

endmodule

// File: rtl/tod_slot_timer.sv
// tod_slot_timer: two-level time-of-day / slot timer.
// tod_l counts 0..FINE_MOD-1, tod_h counts fine wraps. When tod reaches the
// active slot end the next clk restarts at 0/0 with slot_pulse, tod_flag and
// slot/frame numbering. The slot end is written to a shadow register and
// copied into the active end at each slot boundary, so it persists.
// Phase trims are applied one tick per fine wrap by tod_phase_adj.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : tod_slot_timer_if slave (loads, period, adjust in; time, strobes out)
module tod_slot_timer
  import tod_pkg::*;
#(
  parameter int unsigned FINE_W          = TOD_FINE_W,
  parameter int unsigned COARSE_W        = TOD_COARSE_W,
  parameter int unsigned FINE_MOD        = TOD_FINE_MOD,
  parameter int unsigned SLOT_H_DEF      = TOD_SLOT_H_DEF,
  parameter int unsigned SLOT_L_DEF      = TOD_SLOT_L_DEF,
  parameter int unsigned SLOT_W          = TOD_SLOT_W,
  parameter int unsigned SLOTS_PER_FRAME = TOD_SLOTS_PER_FRAME,
  parameter int unsigned ADJ_W           = TOD_ADJ_W
) (
  input  logic               clk,
  input  logic               rst,
  tod_slot_timer_if.slave    bus
);

  typedef struct packed {
    logic [COARSE_W-1:0] h;
    logic [FINE_W-1:0]   l;
  } tod_val_t;

  localparam tod_val_t          END_DEF   = '{h: COARSE_W'(SLOT_H_DEF), l: FINE_W'(SLOT_L_DEF)};
  localparam logic [FINE_W-1:0] FINE_LAST = FINE_W'(FINE_MOD - 1);
  localparam logic [FINE_W-1:0] FINE_ONE  = FINE_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_FRAME - 1);

  tod_val_t          tod;
  tod_val_t          act_end;
  tod_val_t          shd_end;
  logic              tod_flag;
  logic              slot_pulse;
  logic              frame_pulse;
  logic [SLOT_W-1:0] slot_num;

  logic     any_load;
  logic     at_end;
  logic     at_fine_last;
  logic     fine_wrap;
  adj_act_e adj_act;
  logic     adj_busy;
  logic     adj_err;

  assign any_load     = bus.rtt_reload_en | bus.load_en;
  assign at_end       = (tod == act_end);
  assign at_fine_last = (tod.l == FINE_LAST);
  // A boundary on the last fine tick takes precedence, so no adjust is spent.
  assign fine_wrap    = !any_load && !at_end && at_fine_last;

  tod_phase_adj #(
    .ADJ_W (ADJ_W)
  ) u_phase_adj (
    .clk     (clk),
    .rst     (rst),
    .clr     (any_load),
    .wrap    (fine_wrap),
    .adj_req (bus.adj_req),
    .adj_val (bus.adj_val),
    .act     (adj_act),
    .busy    (adj_busy),
    .err     (adj_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tod         <= '0;
      act_end     <= END_DEF;
      shd_end     <= END_DEF;
      tod_flag    <= 1'b0;
      slot_pulse  <= 1'b0;
      frame_pulse <= 1'b0;
      slot_num    <= '0;
    end else begin
      slot_pulse  <= 1'b0;
      frame_pulse <= 1'b0;

      if (bus.per_load_en) begin
        shd_end <= '{h: bus.per_h, l: bus.per_l};
      end

      if (bus.rtt_reload_en) begin
        tod <= '{h: bus.reload_tod_h, l: bus.reload_tod_l};
      end else if (bus.load_en) begin
        // load_data is {tod_h, tod_l}, the same packing as tod_val_t.
        tod <= bus.load_data;
      end else if (at_end) begin
        tod        <= '0;
        tod_flag   <= 1'b1;
        slot_pulse <= 1'b1;
        act_end    <= shd_end;
        if (slot_num == SLOT_LAST) begin
          slot_num    <= '0;
          frame_pulse <= 1'b1;
        end else begin
          slot_num <= slot_num + 1'b1;
        end
      end else if (at_fine_last) begin
        // ADJ_HOLD leaves tod on the last fine tick for one more clk.
        if (adj_act != ADJ_HOLD) begin
          tod.h    <= tod.h + 1'b1;
          tod.l    <= (adj_act == ADJ_SKIP) ? FINE_ONE : '0;
          tod_flag <= 1'b0;
        end
      end else begin
        tod.l <= tod.l + 1'b1;
      end
    end
  end

  assign bus.tod_h       = tod.h;
  assign bus.tod_l       = tod.l;
  assign bus.tod_flag    = tod_flag;
  assign bus.slot_pulse  = slot_pulse;
  assign bus.frame_pulse = frame_pulse;
  assign bus.slot_num    = slot_num;
  assign bus.adj_busy    = adj_busy;
  assign bus.adj_err     = adj_err;

endmodule

// File: tb/tb_tod_slot_timer.sv
// Bench for tod_slot_timer at reduced size: FINE_MOD=10, default slot end
// 3/4 (35 clk), 4 slots per frame. Stimulus pushes expected slot strobes and
// adj_err strobes into queues; a negedge monitor pops and checks them.
module tb_tod_slot_timer;

  localparam int unsigned FW = 4;
  localparam int unsigned CW = 6;
  localparam int unsigned SW = 3;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    int unsigned at;
    int unsigned sn;
    int unsigned fr;
  } slot_ev_t;

  slot_ev_t    slot_q[$];
  int unsigned err_q[$];
  slot_ev_t    ev;
  int unsigned err_at;

  tod_slot_timer_if #(.FINE_W(FW), .COARSE_W(CW), .SLOT_W(SW), .ADJ_W(AW)) bus ();

  tod_slot_timer #(
    .FINE_W          (FW),
    .COARSE_W        (CW),
    .FINE_MOD        (10),
    .SLOT_H_DEF      (3),
    .SLOT_L_DEF      (4),
    .SLOT_W          (SW),
    .SLOTS_PER_FRAME (4),
    .ADJ_W           (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_slot(input int unsigned at, input int unsigned sn, input int unsigned fr);
    slot_ev_t e;
    e.at = at;
    e.sn = sn;
    e.fr = fr;
    slot_q.push_back(e);
  endtask

  task automatic chk_tod(input string name, input int unsigned h, input int unsigned l);
    chk({name, " tod_h"}, 32'(bus.tod_h), h);
    chk({name, " tod_l"}, 32'(bus.tod_l), l);
  endtask

  task automatic chk_all_zero(input string name);
    chk_tod(name, 0, 0);
    chk({name, " tod_flag"},    32'(bus.tod_flag), 0);
    chk({name, " slot_pulse"},  32'(bus.slot_pulse), 0);
    chk({name, " frame_pulse"}, 32'(bus.frame_pulse), 0);
    chk({name, " slot_num"},    32'(bus.slot_num), 0);
    chk({name, " adj_busy"},    32'(bus.adj_busy), 0);
    chk({name, " adj_err"},     32'(bus.adj_err), 0);
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.slot_pulse) begin
      if (slot_q.size() == 0) begin
        chk("slot_pulse unexpected", 32'(bus.slot_pulse), 0);
      end else begin
        ev = slot_q.pop_front();
        chk("slot_pulse cycle", cyc, ev.at);
        chk("slot_num", 32'(bus.slot_num), ev.sn);
        chk("frame_pulse", 32'(bus.frame_pulse), ev.fr);
        chk("slot start tod", 32'({bus.tod_h, bus.tod_l}), 0);
        chk("slot start tod_flag", 32'(bus.tod_flag), 1);
      end
    end
    if (!rst && bus.frame_pulse && !bus.slot_pulse) begin
      chk("frame_pulse without slot_pulse", 32'(bus.frame_pulse), 0);
    end
    if (!rst && bus.adj_err) begin
      if (err_q.size() == 0) begin
        chk("adj_err unexpected", 32'(bus.adj_err), 0);
      end else begin
        err_at = err_q.pop_front();
        chk("adj_err cycle", cyc, err_at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int unsigned r, s, s2, s3, s4, r2;

  initial begin
    bus.rtt_reload_en = 1'b0;
    bus.reload_tod_h  = '0;
    bus.reload_tod_l  = '0;
    bus.load_en       = 1'b0;
    bus.load_data     = '0;
    bus.per_load_en   = 1'b0;
    bus.per_h         = '0;
    bus.per_l         = '0;
    bus.adj_req       = 1'b0;
    bus.adj_val       = '0;

    // Reset state and free run at the default 35-clk slot.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    r = cyc;
    rst = 1'b0;
    push_slot(r + 35, 1, 0);
    push_slot(r + 70, 2, 0);
    push_slot(r + 105, 3, 0);
    wait_cyc(r + 1);
    chk_tod("first clk", 0, 1);
    wait_cyc(r + 44);
    chk("flag end of first fine", 32'(bus.tod_flag), 1);
    chk_tod("first fine last", 0, 9);
    wait_cyc(r + 45);
    chk("flag after first wrap", 32'(bus.tod_flag), 0);
    chk_tod("first wrap", 1, 0);

    // Period 1/2 (13 clk) written mid-slot; takes effect next slot, persists.
    wait_cyc(r + 85);
    bus.per_load_en = 1'b1;
    bus.per_h = 6'd1;
    bus.per_l = 4'd2;
    wait_cyc(r + 86);
    bus.per_load_en = 1'b0;
    push_slot(r + 118, 0, 1);
    push_slot(r + 131, 1, 0);
    push_slot(r + 144, 2, 0);
    push_slot(r + 157, 3, 0);
    push_slot(r + 170, 0, 1);

    // Period 5/3 (54 clk) for the adjust tests.
    wait_cyc(r + 160);
    bus.per_load_en = 1'b1;
    bus.per_h = 6'd5;
    bus.per_l = 4'd3;
    wait_cyc(r + 161);
    bus.per_load_en = 1'b0;

    // Advance by 3: three skipped ticks, slot 51 clk.
    s = r + 170;
    push_slot(s + 51, 1, 0);
    wait_cyc(s + 2);
    bus.adj_req = 1'b1;
    bus.adj_val = 8'sd3;
    wait_cyc(s + 3);
    bus.adj_req = 1'b0;
    chk("adv busy", 32'(bus.adj_busy), 1);
    wait_cyc(s + 9);
    chk_tod("adv before wrap1", 0, 9);
    wait_cyc(s + 10);
    chk_tod("adv wrap1", 1, 1);
    wait_cyc(s + 19);
    chk_tod("adv wrap2", 2, 1);
    wait_cyc(s + 27);
    chk("adv busy before last", 32'(bus.adj_busy), 1);
    wait_cyc(s + 28);
    chk_tod("adv wrap3", 3, 1);
    chk("adv busy done", 32'(bus.adj_busy), 0);

    // Retard by 2: last fine tick held on two wraps, slot 56 clk.
    s2 = s + 51;
    push_slot(s2 + 56, 2, 0);
    wait_cyc(s2 + 2);
    bus.adj_req = 1'b1;
    bus.adj_val = -8'sd2;
    wait_cyc(s2 + 3);
    bus.adj_req = 1'b0;
    wait_cyc(s2 + 10);
    chk_tod("ret hold1", 0, 9);
    chk("ret busy", 32'(bus.adj_busy), 1);
    wait_cyc(s2 + 11);
    chk_tod("ret wrap1", 1, 0);
    wait_cyc(s2 + 21);
    chk_tod("ret hold2", 1, 9);
    wait_cyc(s2 + 22);
    chk_tod("ret wrap2", 2, 0);
    chk("ret busy done", 32'(bus.adj_busy), 0);

    // Saturation: +127 then +1 gives one adj_err strobe.
    s3 = s2 + 56;
    err_q.push_back(s3 + 3);
    wait_cyc(s3 + 1);
    bus.adj_req = 1'b1;
    bus.adj_val = 8'sd127;
    wait_cyc(s3 + 2);
    bus.adj_val = 8'sd1;
    wait_cyc(s3 + 3);
    bus.adj_req = 1'b0;
    bus.adj_val = '0;

    // Reload and load together: reload wins, pending cleared, no strobe.
    wait_cyc(s3 + 5);
    chk("sat busy", 32'(bus.adj_busy), 1);
    bus.rtt_reload_en = 1'b1;
    bus.reload_tod_h  = 6'd2;
    bus.reload_tod_l  = 4'd7;
    bus.load_en       = 1'b1;
    bus.load_data     = {6'd1, 4'd1};
    push_slot(s3 + 33, 3, 0);
    wait_cyc(s3 + 6);
    bus.rtt_reload_en = 1'b0;
    bus.load_en       = 1'b0;
    chk_tod("reload", 2, 7);
    chk("reload busy", 32'(bus.adj_busy), 0);
    chk("reload slot_num", 32'(bus.slot_num), 2);
    chk("reload tod_flag", 32'(bus.tod_flag), 1);
    chk("reload slot_pulse", 32'(bus.slot_pulse), 0);

    // Load on the boundary cycle suppresses that boundary.
    s4 = s3 + 33;
    push_slot(s4 + 68, 0, 1);
    wait_cyc(s4 + 53);
    chk_tod("end tick", 5, 3);
    bus.load_en   = 1'b1;
    bus.load_data = {6'd4, 4'd0};
    wait_cyc(s4 + 54);
    bus.load_en = 1'b0;
    chk_tod("boundary load", 4, 0);
    chk("boundary load slot_pulse", 32'(bus.slot_pulse), 0);
    chk("boundary load slot_num", 32'(bus.slot_num), 3);

    // Async reset mid-slot with an adjust pending.
    wait_cyc(s4 + 70);
    bus.adj_req = 1'b1;
    bus.adj_val = 8'sd5;
    wait_cyc(s4 + 71);
    bus.adj_req = 1'b0;
    wait_cyc(s4 + 75);
    chk("pre-reset busy", 32'(bus.adj_busy), 1);
    chk("pre-reset tod_flag", 32'(bus.tod_flag), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    wait_cyc(s4 + 78);
    r2 = cyc;
    rst = 1'b0;
    push_slot(r2 + 35, 1, 0);
    wait_cyc(r2 + 1);
    chk_tod("restart", 0, 1);

    wait_cyc(r2 + 40);
    chk("slot events left", slot_q.size(), 0);
    chk("adj_err events left", err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
